// File: rtl/fib_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one shift per clock) fed by the Fibonacci generator.
// Optional leading-zero blanking output enabled by defining FIB_BCD_BLANK_EN.
module fib_bcd_converter #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      binIn,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcdOut
`ifdef FIB_BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]     blankMask
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Pre-shift correction: any digit >= 5 would reach >= 10 after doubling.
  function automatic logic [4*DIGITS-1:0] add3_digits(input logic [4*DIGITS-1:0] bcd);
    logic [4*DIGITS-1:0] res;
    res = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end else begin
        res[4*i +: 4] = bcd[4*i +: 4];
      end
    end
    return res;
  endfunction

  function automatic logic [DIGITS-1:0] lead_zero_mask(input logic [4*DIGITS-1:0] bcd);
    logic [DIGITS-1:0] mask;
    logic              all_zero;
    mask     = '0;
    all_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (bcd[4*i +: 4] != 4'd0) begin
        all_zero = 1'b0;
      end else begin
        all_zero = all_zero;
      end
      mask[i] = all_zero;
    end
    // Units digit is never blanked so zero still displays as "0".
    mask[0] = 1'b0;
    return mask;
  endfunction

  state_t                state_r;
  state_t                state_next_s;
  logic                  load_s;
  logic                  last_s;
  logic [WIDTH-1:0]      bin_r;
  logic [4*DIGITS-1:0]   bcd_work_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [4*DIGITS-1:0]   bcd_out_r;
  logic                  busy_r;
  logic                  done_r;
  logic [4*DIGITS-1:0]   corr_s;
  logic [4*DIGITS-1:0]   bcd_shift_s;
  logic [WIDTH-1:0]      bin_shift_s;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic and load/complete strobes.
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    last_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = SHIFT;
          load_s       = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r == LAST_ITER) begin
          state_next_s = DONE;
          last_s       = 1'b1;
        end else begin
          state_next_s = SHIFT;
        end
      end
      DONE: begin
        if (start) begin
          state_next_s = SHIFT;
          load_s       = 1'b1;
        end else begin
          state_next_s = DONE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // One double-dabble iteration: correct, then shift {bcd, bin} left by one.
  always_comb begin
    corr_s      = add3_digits(bcd_work_r);
    bcd_shift_s = {corr_s[4*DIGITS-2:0], bin_r[WIDTH-1]};
    bin_shift_s = {bin_r[WIDTH-2:0], 1'b0};
  end

  // Working registers, iteration counter and result register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_r      <= '0;
      bcd_work_r <= '0;
      cnt_r      <= '0;
      bcd_out_r  <= '0;
    end else if (load_s) begin
      bin_r      <= binIn;
      bcd_work_r <= '0;
      cnt_r      <= '0;
    end else if (state_r == SHIFT) begin
      bin_r      <= bin_shift_s;
      bcd_work_r <= bcd_shift_s;
      cnt_r      <= cnt_r + CNT_ONE;
      if (last_s) begin
        bcd_out_r <= bcd_shift_s;
      end else begin
        bcd_out_r <= bcd_out_r;
      end
    end else begin
      bin_r      <= bin_r;
      bcd_work_r <= bcd_work_r;
      cnt_r      <= cnt_r;
      bcd_out_r  <= bcd_out_r;
    end
  end

  // Status flags registered from the next state so they align with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_next_s == SHIFT);
      done_r <= (state_next_s == DONE);
    end
  end

`ifdef FIB_BCD_BLANK_EN
  logic [DIGITS-1:0] blank_r;
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  // Leading-zero mask, refreshed together with the result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blank_r <= BLANK_RST;
    end else if ((state_r == SHIFT) && last_s) begin
      blank_r <= lead_zero_mask(bcd_shift_s);
    end else begin
      blank_r <= blank_r;
    end
  end

  assign blankMask = blank_r;
`endif

  assign busy   = busy_r;
  assign done   = done_r;
  assign bcdOut = bcd_out_r;

endmodule

// File: tb/tb_fib_bcd_converter.sv
// Directed, table-driven bench for fib_bcd_converter, plus hand-written multi-cycle corner sequences.
// Checks blankMask as well when FIB_BCD_BLANK_EN is defined.
module tb_fib_bcd_converter;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] binIn;
  logic        busy;
  logic        done;
  logic [19:0] bcdOut;
`ifdef FIB_BCD_BLANK_EN
  logic [4:0]  blankMask;
`endif

  int checks;
  int failures;

  typedef struct {
    logic [15:0] bin;
    logic [19:0] bcd;
    logic [4:0]  blank;
  } vec_t;

  vec_t vecs[8];

  fib_bcd_converter #(.WIDTH(16), .DIGITS(5)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .binIn  (binIn),
    .busy   (busy),
    .done   (done),
    .bcdOut (bcdOut)
`ifdef FIB_BCD_BLANK_EN
    ,
    .blankMask (blankMask)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Independent decimal model: repeated division by ten.
  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int          t;
    t = v;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic do_load(input logic [15:0] v);
    binIn = v;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after the load edge until done rises; bounded.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  int cyc;
  int fib_a;
  int fib_b;
  int fib_t;

  initial begin
    checks   = 0;
    failures = 0;
    vecs[0] = '{16'd46368, 20'h46368, 5'b00000};
    vecs[1] = '{16'd0,     20'h00000, 5'b11110};
    vecs[2] = '{16'd65535, 20'h65535, 5'b00000};
    vecs[3] = '{16'd1597,  20'h01597, 5'b10000};
    vecs[4] = '{16'd233,   20'h00233, 5'b11000};
    vecs[5] = '{16'd9,     20'h00009, 5'b11110};
    vecs[6] = '{16'd10000, 20'h10000, 5'b00000};
    vecs[7] = '{16'd99,    20'h00099, 5'b11100};

    reset = 1'b1;
    start = 1'b0;
    binIn = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_bcd", {12'd0, bcdOut}, 32'd0);
`ifdef FIB_BCD_BLANK_EN
    check("reset_blank", {27'd0, blankMask}, 32'h1E);
`endif
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_no_start", {30'd0, busy, done}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      do_load(vecs[i].bin);
      check($sformatf("v%0d_busy_after_load", i), {30'd0, busy, done}, 32'd2);
      binIn = 16'h5A5A;
      wait_done(cyc);
      check($sformatf("v%0d_latency", i), cyc, 32'd16);
      check($sformatf("v%0d_bcd", i), {12'd0, bcdOut}, {12'd0, vecs[i].bcd});
      check($sformatf("v%0d_busy_end", i), {31'd0, busy}, 32'd0);
`ifdef FIB_BCD_BLANK_EN
      check($sformatf("v%0d_blank", i), {27'd0, blankMask}, {27'd0, vecs[i].blank});
`endif
    end

    // start during SHIFT is ignored
    do_load(16'd233);
    repeat (4) @(posedge clk);
    #1;
    binIn = 16'd999;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ign_busy_mid", {31'd0, busy}, 32'd1);
    wait_done(cyc);
    check("ign_latency", cyc, 32'd11);
    check("ign_bcd", {12'd0, bcdOut}, 32'h00233);

    // restart from DONE: old result held during SHIFT
    do_load(16'd987);
    check("restart_done_low", {31'd0, done}, 32'd0);
    check("restart_bcd_hold0", {12'd0, bcdOut}, 32'h00233);
    repeat (8) @(posedge clk);
    #1;
    check("restart_bcd_hold8", {12'd0, bcdOut}, 32'h00233);
    wait_done(cyc);
    check("restart_latency", cyc, 32'd8);
    check("restart_bcd", {12'd0, bcdOut}, 32'h00987);

    // asynchronous reset mid-conversion
    do_load(16'd4181);
    repeat (8) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_busy", {31'd0, busy}, 32'd0);
    check("async_done", {31'd0, done}, 32'd0);
    check("async_bcd", {12'd0, bcdOut}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("post_reset_idle", {30'd0, busy, done}, 32'd0);
    do_load(16'd4181);
    wait_done(cyc);
    check("post_reset_latency", cyc, 32'd16);
    check("post_reset_bcd", {12'd0, bcdOut}, 32'h04181);

    // start held high, binIn stepping through the Fibonacci sequence
    fib_a = 1;
    fib_b = 1;
    start = 1'b1;
    while (fib_a <= 46368) begin
      binIn = 16'(fib_a);
      @(posedge clk);
      #1;
      binIn = 16'hFFFF;
      wait_done(cyc);
      check($sformatf("fib_%0d_latency", fib_a), cyc, 32'd16);
      check($sformatf("fib_%0d_bcd", fib_a), {12'd0, bcdOut}, {12'd0, to_bcd(fib_a)});
      fib_t = fib_a + fib_b;
      fib_a = fib_b;
      fib_b = fib_t;
    end
    start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
